board_state_regs: RTL and testbench
===================================

Name: board_state_regs

Overview:
- Parametrised successor to the fixed 9-cell game-board register: a ROWS x COLS grid of 2-bit cell owners.
- Validates each move internally: index range, occupancy, turn order and board-full. Callers no longer supply an illegal-move flag.
- Adds a move-history stack with single-step undo, a move counter, a turn tracker and a full flag.
- Sits between the keypad/move decoder and the win checker and display logic.

Parameters:
- ROWS, 3, grid rows (>=1).
- COLS, 3, grid columns (>=1). N = ROWS*COLS, N >= 2.
- FIRST_PLAYER, 0, player moving first after reset/clear (0 = player1, 1 = player2).
- Derived: IDX_W = $clog2(N); CNT_W = $clog2(N+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- clear  in  1  new game; same effect as rst, one-cycle strobe.
- move_valid  in  1  move request strobe.
- move_player  in  1  requesting player (0 = player1, 1 = player2).
- move_idx  in  IDX_W  target cell, row-major (idx = row*COLS + col).
- undo  in  1  undo-last-move strobe.
- board  out  2*N  cell k at [2k+1:2k]: 00 empty, 01 player1, 10 player2; 11 never produced.
- turn  out  1  player expected to move next.
- move_count  out  CNT_W  number of occupied cells.
- board_full  out  1  move_count == N.
- move_ack  out  1  one-cycle pulse: move accepted.
- move_illegal  out  1  one-cycle pulse: move rejected.
- undo_ack  out  1  one-cycle pulse: undo performed.

Behaviour:
- All state and outputs are registered and update only on rising clk.
- Reset and clear values: board = 0, turn = FIRST_PLAYER, move_count = 0, board_full = 0, all pulses 0, history pointer = 0. History contents need not be reset.
- Priority per cycle: rst > clear > undo > move_valid.
- Legal move, when move_valid=1 and none of the following hold:
  - move_idx >= N;
  - cell move_idx != 00;
  - move_player != turn;
  - board_full = 1.
- Legal move, effect on the next edge:
  - cell <= 01 or 10 according to move_player;
  - history[move_count] <= move_idx;
  - move_count += 1;
  - turn toggles;
  - move_ack = 1 for exactly one cycle.
- Illegal move: board, turn, move_count and history unchanged; move_illegal = 1 for one cycle.
- Undo with move_count > 0:
  - cell history[move_count-1] <= 00;
  - move_count -= 1;
  - turn toggles;
  - undo_ack = 1 for one cycle.
- Undo with move_count = 0: no state change, no pulse.
- Undo and move_valid in the same cycle: undo is processed, the move is discarded and move_illegal = 1. The illegal pulse fires even if undo itself was a no-op.
- clear with undo and/or move_valid: only clear acts; no pulses.
- Latency: the board, turn, count and pulse outputs all reflect the request one cycle after it is sampled. Back-to-back requests every cycle are supported; each is evaluated against the state already updated by the previous cycle.
- board_full = (move_count == N), registered with move_count. Once full, every move is illegal until an undo, clear or rst.
- History depth is N entries, so it can never overflow: a push is only possible while move_count < N.
- Only one cell changes per cycle. move_ack, move_illegal and undo_ack are mutually exclusive, except that undo_ack and move_illegal may both be 1 in the simultaneous undo-and-move case.

Test Plan:
- Default 3x3: reset, then player 0 at idx 4 -> next cycle board[9:8]=01, turn=1, move_count=1, move_ack=1 for one cycle.
- Move order 0@4, 1@4 -> second move flags move_illegal=1; board[9:8] stays 01; turn=1; count=1. Then 0@0 while turn=1 -> illegal, no change. Then move_idx=9 -> illegal.
- Fill all 9 cells with legal alternating moves -> board_full=1 and move_count=9. A tenth move -> move_illegal=1. Then undo -> last cell = 00, count=8, board_full=0, undo_ack=1, turn toggles back.
- Three legal moves, then three undos on consecutive cycles -> board=0, count=0, turn=FIRST_PLAYER. A fourth undo -> no pulse, no change.
- Same cycle undo=1 with a legal move after 2 moves -> undo_ack=1, move_illegal=1, count=1, the move is not written. Same cycle clear=1 with move_valid=1 -> board=0 and no pulses.
- ROWS=6, COLS=7, FIRST_PLAYER=1: player 1 at idx 41 -> board[83:82]=10 and turn=0. Assert rst mid-game -> the next cycle shows all outputs at their reset values.

Source files
------------

// File: rtl/board_state_regs.sv
// Purpose : ROWS x COLS game-board register with move validation, turn tracking,
//           move counter, full flag and a move-history stack for single-step undo.
// Latency : every request is reflected on all outputs one clock after it is sampled.
// Backpressure: none; a request may arrive every cycle and sees the state from the previous one.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   clear              new-game strobe, same effect as rst
//   move_valid/_player/_idx  move request (row-major cell index)
//   undo               undo-last-move strobe
//   board              2 bits per cell: 00 empty, 01 player1, 10 player2
//   turn, move_count, board_full   game state
//   move_ack, move_illegal, undo_ack   one-cycle result pulses
module board_state_regs #(
  parameter int   ROWS         = 3,
  parameter int   COLS         = 3,
  parameter logic FIRST_PLAYER = 1'b0,
  localparam int  N            = ROWS * COLS,
  localparam int  IDX_W        = $clog2(N),
  localparam int  CNT_W        = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             move_valid,
  input  logic             move_player,
  input  logic [IDX_W-1:0] move_idx,
  input  logic             undo,
  output logic [2*N-1:0]   board,
  output logic             turn,
  output logic [CNT_W-1:0] move_count,
  output logic             board_full,
  output logic             move_ack,
  output logic             move_illegal,
  output logic             undo_ack
);

  // One extra bit so that N itself is representable when N is a power of two.
  localparam logic [IDX_W:0] N_X = (IDX_W + 1)'(N);
  localparam logic [CNT_W-1:0] N_C = CNT_W'(N);

  logic [2*N-1:0]   board_q, board_d;
  logic             turn_q, turn_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             ack_q, ack_d;
  logic             ill_q, ill_d;
  logic             uack_q, uack_d;
  logic [IDX_W-1:0] hist_q [N];
  logic [IDX_W-1:0] hist_d [N];

  logic [1:0]       cell_cur;
  logic [IDX_W-1:0] last_idx;
  logic             idx_ok;
  logic             legal;

  always_comb begin
    board_d  = board_q;
    turn_d   = turn_q;
    count_d  = count_q;
    hist_d   = hist_q;
    ack_d    = 1'b0;
    ill_d    = 1'b0;
    uack_d   = 1'b0;

    // Cell lookup by loop so an out-of-range index simply reads as empty
    // (it is rejected by idx_ok anyway) instead of slicing past the bus.
    cell_cur = 2'b00;
    for (int k = 0; k < N; k++) begin
      if (move_idx == IDX_W'(k)) cell_cur = board_q[2*k +: 2];
    end

    // Top of the history stack: entry move_count-1.
    last_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (count_q == CNT_W'(k + 1)) last_idx = hist_q[k];
    end

    idx_ok = ({1'b0, move_idx} < N_X);
    legal  = idx_ok && (cell_cur == 2'b00) && (move_player == turn_q) && !full_q;

    if (clear) begin
      board_d = '0;
      turn_d  = FIRST_PLAYER;
      count_d = '0;
    end else if (undo) begin
      // A move arriving with an undo is always discarded and reported.
      ill_d = move_valid;
      if (count_q != '0) begin
        for (int k = 0; k < N; k++) begin
          if (last_idx == IDX_W'(k)) board_d[2*k +: 2] = 2'b00;
        end
        count_d = count_q - CNT_W'(1);
        turn_d  = ~turn_q;
        uack_d  = 1'b1;
      end
    end else if (move_valid) begin
      if (legal) begin
        for (int k = 0; k < N; k++) begin
          if (move_idx == IDX_W'(k)) board_d[2*k +: 2] = move_player ? 2'b10 : 2'b01;
        end
        // Push; count_q < N here so the stack cannot overflow.
        for (int k = 0; k < N; k++) begin
          if (count_q == CNT_W'(k)) hist_d[k] = move_idx;
        end
        count_d = count_q + CNT_W'(1);
        turn_d  = ~turn_q;
        ack_d   = 1'b1;
      end else begin
        ill_d = 1'b1;
      end
    end

    full_d = (count_d == N_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board_q <= '0;
      turn_q  <= FIRST_PLAYER;
      count_q <= '0;
      full_q  <= 1'b0;
      ack_q   <= 1'b0;
      ill_q   <= 1'b0;
      uack_q  <= 1'b0;
    end else begin
      board_q <= board_d;
      turn_q  <= turn_d;
      count_q <= count_d;
      full_q  <= full_d;
      ack_q   <= ack_d;
      ill_q   <= ill_d;
      uack_q  <= uack_d;
    end
  end

  // History contents are only meaningful below move_count, so no reset.
  always_ff @(posedge clk) begin
    hist_q <= hist_d;
  end

  assign board        = board_q;
  assign turn         = turn_q;
  assign move_count   = count_q;
  assign board_full   = full_q;
  assign move_ack     = ack_q;
  assign move_illegal = ill_q;
  assign undo_ack     = uack_q;

endmodule

// File: tb/tb_board_state_regs.sv
// Bench for board_state_regs: a default 3x3 instance and a 6x7 instance with
// player2 moving first, both compared every cycle against a request-level model.
module tb_board_state_regs;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: 3x3, FIRST_PLAYER = 0
  logic        rst0 = 0, clear0 = 0, mv0 = 0, mp0 = 0, undo0 = 0;
  logic [3:0]  idx0 = 0;
  logic [17:0] board0;
  logic        turn0, full0, ack0, ill0, uack0;
  logic [3:0]  cnt0;

  // Instance 1: 6x7, FIRST_PLAYER = 1
  logic        rst1 = 0, clear1 = 0, mv1 = 0, mp1 = 0, undo1 = 0;
  logic [5:0]  idx1 = 0;
  logic [83:0] board1;
  logic        turn1, full1, ack1, ill1, uack1;
  logic [5:0]  cnt1;

  board_state_regs dut0 (
    .clk(clk), .rst(rst0), .clear(clear0), .move_valid(mv0), .move_player(mp0),
    .move_idx(idx0), .undo(undo0), .board(board0), .turn(turn0), .move_count(cnt0),
    .board_full(full0), .move_ack(ack0), .move_illegal(ill0), .undo_ack(uack0)
  );

  board_state_regs #(.ROWS(6), .COLS(7), .FIRST_PLAYER(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .clear(clear1), .move_valid(mv1), .move_player(mp1),
    .move_idx(idx1), .undo(undo1), .board(board1), .turn(turn1), .move_count(cnt1),
    .board_full(full1), .move_ack(ack1), .move_illegal(ill1), .undo_ack(uack1)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- request-level game model ----------------
  int m_n[2]     = '{9, 42};
  bit m_first[2] = '{1'b0, 1'b1};
  int m_cell[2][42];      // 0 empty, 1 player1, 2 player2
  int m_hist[2][42];      // indices of accepted moves, oldest first
  int m_cnt[2];
  bit m_turn[2];
  bit e_ack[2], e_ill[2], e_uack[2];

  task automatic mstep(int u, bit r, bit c, bit mv, bit p, int idx, bit un);
    e_ack[u] = 0; e_ill[u] = 0; e_uack[u] = 0;
    if (r || c) begin
      for (int k = 0; k < 42; k++) m_cell[u][k] = 0;
      m_cnt[u]  = 0;
      m_turn[u] = m_first[u];
    end else if (un) begin
      if (m_cnt[u] > 0) begin
        m_cnt[u]--;
        m_cell[u][m_hist[u][m_cnt[u]]] = 0;
        m_turn[u] = !m_turn[u];
        e_uack[u] = 1;
      end
      if (mv) e_ill[u] = 1;
    end else if (mv) begin
      if (idx < m_n[u] && m_cell[u][idx] == 0 && p == m_turn[u] && m_cnt[u] < m_n[u]) begin
        m_cell[u][idx]      = p ? 2 : 1;
        m_hist[u][m_cnt[u]] = idx;
        m_cnt[u]++;
        m_turn[u] = !m_turn[u];
        e_ack[u]  = 1;
      end else begin
        e_ill[u] = 1;
      end
    end
  endtask

  function automatic logic [83:0] exp_board(int u);
    logic [83:0] b = '0;
    for (int k = 0; k < m_n[u]; k++) b[2*k +: 2] = 2'(m_cell[u][k]);
    return b;
  endfunction

  // Per-cycle compare of both instances against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      logic [83:0] b0, b1;
      b0 = exp_board(0);
      b1 = exp_board(1);
      chk("u0_board", board0, b0[17:0]);
      chk("u0_turn",  turn0,  m_turn[0]);
      chk("u0_count", cnt0,   m_cnt[0]);
      chk("u0_full",  full0,  m_cnt[0] == 9);
      chk("u0_ack",   ack0,   e_ack[0]);
      chk("u0_ill",   ill0,   e_ill[0]);
      chk("u0_uack",  uack0,  e_uack[0]);
      chk("u1_board", board1, b1);
      chk("u1_turn",  turn1,  m_turn[1]);
      chk("u1_count", cnt1,   m_cnt[1]);
      chk("u1_full",  full1,  m_cnt[1] == 42);
      chk("u1_ack",   ack1,   e_ack[1]);
      chk("u1_ill",   ill1,   e_ill[1]);
      chk("u1_uack",  uack1,  e_uack[1]);
    end
  end

  // One request to instance u for one cycle; the other instance idles.
  task automatic cyc(int u, bit r, bit c, bit mv, bit p, int idx, bit un);
    @(negedge clk);
    rst0 = 0; clear0 = 0; mv0 = 0; mp0 = 0; idx0 = 0; undo0 = 0;
    rst1 = 0; clear1 = 0; mv1 = 0; mp1 = 0; idx1 = 0; undo1 = 0;
    if (u == 0) begin
      rst0 = r; clear0 = c; mv0 = mv; mp0 = p; idx0 = 4'(idx); undo0 = un;
    end else begin
      rst1 = r; clear1 = c; mv1 = mv; mp1 = p; idx1 = 6'(idx); undo1 = un;
    end
    @(posedge clk);
    mstep(u, r, c, mv, p, idx, un);
    mstep(1 - u, 0, 0, 0, 0, 0, 0);
    #1;
  endtask

  task automatic mv(int u, bit p, int idx);
    cyc(u, 0, 0, 1, p, idx, 0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk_en = 1;
    // literal reset values
    chk("lit_rst_board", board0, 18'h0);
    chk("lit_rst_turn1", turn1, 1'b1);
    chk("lit_rst_cnt",   cnt0, 4'd0);

    // first move
    mv(0, 0, 4);
    chk("lit_b4",    board0[9:8], 2'b01);
    chk("lit_turn",  turn0, 1'b1);
    chk("lit_cnt1",  cnt0, 4'd1);
    chk("lit_ack",   ack0, 1'b1);
    idle();
    chk("lit_ack_drop", ack0, 1'b0);

    // occupied, wrong turn, out of range
    mv(0, 1, 4);
    chk("lit_occ_ill", ill0, 1'b1);
    chk("lit_occ_b4",  board0[9:8], 2'b01);
    mv(0, 0, 0);
    chk("lit_turn_ill", ill0, 1'b1);
    mv(0, 1, 9);
    chk("lit_range_ill", ill0, 1'b1);
    mv(0, 1, 15);
    idle();

    // fill the board, back-to-back
    mv(0, 1, 0); mv(0, 0, 1); mv(0, 1, 2); mv(0, 0, 3);
    mv(0, 1, 5); mv(0, 0, 6); mv(0, 1, 7); mv(0, 0, 8);
    chk("lit_full",     full0, 1'b1);
    chk("lit_full_cnt", cnt0, 4'd9);
    mv(0, 1, 0);
    chk("lit_full_ill", ill0, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit_undo_b8",   board0[17:16], 2'b00);
    chk("lit_undo_cnt",  cnt0, 4'd8);
    chk("lit_undo_full", full0, 1'b0);
    chk("lit_undo_turn", turn0, 1'b0);

    // three moves, three undos, one extra undo
    cyc(0, 0, 1, 0, 0, 0, 0);
    mv(0, 0, 0); mv(0, 1, 1); mv(0, 0, 2);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit_empty_board", board0, 18'h0);
    chk("lit_empty_turn",  turn0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit_noop_uack", uack0, 1'b0);

    // undo with a simultaneous move
    mv(0, 0, 3); mv(0, 1, 5);
    cyc(0, 0, 0, 1, 0, 6, 1);
    chk("lit_um_uack",  uack0, 1'b1);
    chk("lit_um_ill",   ill0, 1'b1);
    chk("lit_um_cnt",   cnt0, 4'd1);
    chk("lit_um_board", board0, 18'h40);
    // no-op undo with a move still flags the move
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 2, 1);
    // clear with a move
    mv(0, 0, 7);
    cyc(0, 0, 1, 1, 1, 0, 0);
    chk("lit_clr_board", board0, 18'h0);
    chk("lit_clr_ack",   ack0, 1'b0);
    chk("lit_clr_ill",   ill0, 1'b0);
    // rst beats undo
    mv(0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 1);

    // 6x7 instance, player2 first
    mv(1, 1, 41);
    chk("lit_u1_b41",  board1[83:82], 2'b10);
    chk("lit_u1_turn", turn1, 1'b0);
    mv(1, 0, 0);
    mv(1, 0, 20);
    cyc(1, 1, 0, 1, 1, 5, 0);
    chk("lit_u1_rst_board", board1, 84'h0);
    chk("lit_u1_rst_turn",  turn1, 1'b1);
    chk("lit_u1_rst_cnt",   cnt1, 6'd0);
    chk("lit_u1_rst_ack",   ack1, 1'b0);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
